// File: rtl/ni_packetizer_if.sv
// Host request/payload handshake plus router local-port link of the NI transmit stage.
// The packetizer uses the master modport; the host/router model uses the slave modport.
interface ni_packetizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AXIS       = 4
);
  logic                  req_valid;
  logic [AXIS-1:0]       req_dst;
  logic [11:0]           req_len;
  logic                  req_ready;
  logic                  pl_valid;
  logic [27:0]           pl_data;
  logic                  pl_ready;
  logic                  err_len;
  logic [DATA_WIDTH-1:0] TX;
  logic                  RTS;
  logic                  DCTS;

  modport master (
    input  req_valid, req_dst, req_len, pl_valid, pl_data, DCTS,
    output req_ready, pl_ready, err_len, TX, RTS
  );

  modport slave (
    output req_valid, req_dst, req_len, pl_valid, pl_data, DCTS,
    input  req_ready, pl_ready, err_len, TX, RTS
  );
endinterface

// File: rtl/ni_packetizer.sv
// NI transmit stage: turns a (dst, len) request plus payload stream into
// header/body/tail flits for a router local port, paced by the router CTS.
module ni_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int AXIS       = 4,
  parameter int MAX_LEN    = 4094,
  parameter int PKT_ID_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AXIS-1:0] cur_addr,
  ni_packetizer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2
  } state_t;

  localparam logic [2:0] ID_HEAD = 3'b001;
  localparam logic [2:0] ID_BODY = 3'b010;
  localparam logic [2:0] ID_TAIL = 3'b100;

  function automatic logic [DATA_WIDTH-1:0] add_parity(input logic [DATA_WIDTH-1:1] bits);
    return {bits, ^bits};
  endfunction

  state_t                state_r, state_s;
  logic [AXIS-1:0]       dst_r, dst_s;
  logic [11:0]           len_r, len_s;
  logic [11:0]           cnt_r, cnt_s;
  logic [PKT_ID_W-1:0]   pkt_id_r, pkt_id_s;
  logic [DATA_WIDTH-1:0] tx_r, tx_s;
  logic                  rts_r, rts_s;
  logic                  err_r, err_s;
  logic                  req_ready_s, pl_ready_s;
  logic                  len_bad_s;

  assign len_bad_s = (bus.req_len == 12'd0) || (bus.req_len > 12'(MAX_LEN));

  // Next-state, flit assembly and handshake decode.
  always_comb begin
    state_s     = state_r;
    dst_s       = dst_r;
    len_s       = len_r;
    cnt_s       = cnt_r;
    pkt_id_s    = pkt_id_r;
    tx_s        = tx_r;
    rts_s       = 1'b0;
    err_s       = 1'b0;
    req_ready_s = 1'b0;
    pl_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        req_ready_s = 1'b1;
        if (bus.req_valid) begin
          if (len_bad_s) begin
            err_s = 1'b1;
          end else begin
            dst_s   = bus.req_dst;
            len_s   = bus.req_len;
            cnt_s   = bus.req_len;
            state_s = HEADER;
          end
        end else begin
          state_s = IDLE;
        end
      end
      HEADER: begin
        if (bus.DCTS) begin
          tx_s    = add_parity({ID_HEAD, len_r + 12'd1, dst_r, cur_addr, pkt_id_r});
          rts_s   = 1'b1;
          state_s = BODY;
        end else begin
          rts_s = 1'b0;
        end
      end
      BODY: begin
        pl_ready_s = bus.DCTS;
        if (bus.pl_valid && bus.DCTS) begin
          rts_s = 1'b1;
          cnt_s = cnt_r - 12'd1;
          // Last payload word of the packet closes it as a tail flit.
          if (cnt_r == 12'd1) begin
            tx_s     = add_parity({ID_TAIL, bus.pl_data});
            pkt_id_s = pkt_id_r + {{(PKT_ID_W-1){1'b0}}, 1'b1};
            state_s  = IDLE;
          end else begin
            tx_s = add_parity({ID_BODY, bus.pl_data});
          end
        end else begin
          rts_s = 1'b0;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, packet context and registered router outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      dst_r    <= {AXIS{1'b0}};
      len_r    <= 12'd0;
      cnt_r    <= 12'd0;
      pkt_id_r <= {PKT_ID_W{1'b0}};
      tx_r     <= {DATA_WIDTH{1'b0}};
      rts_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      dst_r    <= dst_s;
      len_r    <= len_s;
      cnt_r    <= cnt_s;
      pkt_id_r <= pkt_id_s;
      tx_r     <= tx_s;
      rts_r    <= rts_s;
      err_r    <= err_s;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.pl_ready  = pl_ready_s;
  assign bus.err_len   = err_r;
  assign bus.TX        = tx_r;
  assign bus.RTS       = rts_r;

endmodule

// File: tb/tb_ni_packetizer.sv
// Scenario bench for ni_packetizer: expected flits are queued as stimulus is
// driven, observed strobes are collected by a monitor and compared per scenario.
module tb_ni_packetizer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cur_addr = 4'h3;

  ni_packetizer_if #(.DATA_WIDTH(32), .AXIS(4)) bus ();

  ni_packetizer dut (
    .clk      (clk),
    .rst      (rst),
    .cur_addr (cur_addr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          rd_idx = 0;
  logic [7:0]  exp_pkt_id = 8'h00;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Router-side monitor: every write strobe is one delivered flit.
  always @(negedge clk) begin
    if (!rst && bus.RTS) begin
      got_q.push_back(bus.TX);
      got_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_flit(input logic [2:0] id, input logic [27:0] body);
    logic [30:0] b;
    b = {id, body};
    return {b, ^b};
  endfunction

  // Drives one request and its payload; aborts after abort_after words if >= 0.
  task automatic send_packet(input logic [3:0] dst, input logic [11:0] len, input logic [27:0] base,
                             input int stall, input int abort_after);
    int budget;
    int consumed;
    logic ok;
    budget = 0;
    while (!bus.req_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_ready_wait got=%b want=1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_dst   = dst;
    bus.req_len   = len;
    bus.pl_valid  = 1'b1;
    bus.pl_data   = base;
    exp_q.push_back(mk_flit(3'b001, {len + 12'd1, dst, cur_addr, exp_pkt_id}));
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    if (stall > 0) begin
      bus.DCTS = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
      bus.DCTS = 1'b1;
    end
    consumed = 0;
    for (int i = 0; i < int'(len) && (abort_after < 0 || i < abort_after); i++) begin
      bus.pl_data  = base + 28'(i);
      bus.pl_valid = 1'b1;
      ok = 1'b0;
      budget = 0;
      while (!ok && budget < 50) begin
        @(negedge clk);
        ok = bus.pl_ready;
        @(posedge clk); #1;
        budget++;
      end
      if (!ok) begin
        total++;
        bad++;
        $display("FAIL pl_ready_wait got=0 want=1 word=%0d", i);
        break;
      end
      exp_q.push_back(mk_flit((i == int'(len) - 1) ? 3'b100 : 3'b010, base + 28'(i)));
      consumed++;
    end
    bus.pl_valid = 1'b0;
    if (consumed == int'(len)) exp_pkt_id = exp_pkt_id + 8'h01;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_dst = 4'h0; bus.req_len = 12'd0;
    bus.pl_valid = 1'b0; bus.pl_data = 28'h0; bus.DCTS = 1'b1;
    rst = 1'b1;
    #12;
    total++;
    if ({bus.TX, bus.RTS, bus.req_ready, bus.err_len, bus.pl_ready} !== {32'h0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got TX=%h RTS=%b rr=%b err=%b plr=%b want 0,0,1,0,0",
               bus.TX, bus.RTS, bus.req_ready, bus.err_len, bus.pl_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 1'b1; bus.req_dst = 4'h5; bus.req_len = 12'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.RTS !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_header got=%b want=1", bus.RTS);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.TX, bus.RTS, bus.req_ready} !== {32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_async got TX=%h RTS=%b rr=%b want 0,0,1", bus.TX, bus.RTS, bus.req_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pkt_id = 8'h00;
  endtask

  task automatic test_basic();
    int base;
    logic [31:0] e;
    base = rd_idx;
    send_packet(4'h0, 12'd3, 28'h1, 0, -1);
    repeat (3) @(posedge clk); #1;
    total++;
    if (got_q.size() - base !== 4) begin
      bad++;
      $display("FAIL basic_count got=%0d want=4", got_q.size() - base);
    end else begin
      total++;
      if (got_q[base] !== mk_flit(3'b001, {12'd4, 4'h0, 4'h3, 8'h00})) begin
        bad++;
        $display("FAIL basic_header got=%h want=%h", got_q[base], mk_flit(3'b001, {12'd4, 4'h0, 4'h3, 8'h00}));
      end
      total++;
      if (got_cyc[base + 3] - got_cyc[base] !== 3) begin
        bad++;
        $display("FAIL basic_back_to_back got=%0d want=3", got_cyc[base + 3] - got_cyc[base]);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if ((^got_q[base + i]) !== 1'b0) begin
          bad++;
          $display("FAIL basic_parity flit=%0d got=%h want even", i, got_q[base + i]);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < got_q.size()) begin
        total++;
        if (got_q[rd_idx] !== e) begin
          bad++;
          $display("FAIL basic_flit idx=%0d got=%h want=%h", rd_idx, got_q[rd_idx], e);
        end
        rd_idx++;
      end
    end
    rd_idx = got_q.size();
  endtask

  task automatic test_stall();
    int base;
    logic [31:0] e;
    base = rd_idx;
    send_packet(4'h9, 12'd3, 28'h100, 5, -1);
    repeat (3) @(posedge clk); #1;
    total++;
    if (got_q.size() - base !== 4) begin
      bad++;
      $display("FAIL stall_count got=%0d want=4", got_q.size() - base);
    end else begin
      total++;
      if (got_cyc[base + 1] - got_cyc[base] !== 6) begin
        bad++;
        $display("FAIL stall_gap got=%0d want=6", got_cyc[base + 1] - got_cyc[base]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < got_q.size()) begin
        total++;
        if (got_q[rd_idx] !== e) begin
          bad++;
          $display("FAIL stall_flit idx=%0d got=%h want=%h", rd_idx, got_q[rd_idx], e);
        end
        rd_idx++;
      end
    end
    rd_idx = got_q.size();
  endtask

  task automatic test_len_error();
    logic [11:0] lens [2];
    lens[0] = 12'd0;
    lens[1] = 12'd4095;
    for (int k = 0; k < 2; k++) begin
      bus.req_valid = 1'b1; bus.req_dst = 4'h1; bus.req_len = lens[k];
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      total++;
      if ({bus.err_len, bus.req_ready, bus.RTS} !== 3'b110) begin
        bad++;
        $display("FAIL len_err_pulse len=%0d got err=%b rr=%b rts=%b want 1,1,0",
                 lens[k], bus.err_len, bus.req_ready, bus.RTS);
      end
      @(posedge clk); #1;
      total++;
      if ({bus.err_len, bus.req_ready, bus.RTS} !== 3'b010) begin
        bad++;
        $display("FAIL len_err_clear len=%0d got err=%b rr=%b rts=%b want 0,1,0",
                 lens[k], bus.err_len, bus.req_ready, bus.RTS);
      end
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (got_q.size() !== rd_idx) begin
      bad++;
      $display("FAIL len_err_flits got=%0d want=0", got_q.size() - rd_idx);
    end
    rd_idx = got_q.size();
  endtask

  task automatic test_back_to_back();
    int base;
    logic [31:0] e;
    base = rd_idx;
    exp_pkt_id = 8'h00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 257; i++) send_packet(4'(i), 12'd1, 28'(i + 1000), 0, -1);
    repeat (3) @(posedge clk); #1;
    total++;
    if (got_q.size() - base !== 514) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=514", got_q.size() - base);
    end else begin
      total++;
      if ({got_q[base + 510][8:1], got_q[base + 512][8:1]} !== 16'hFF00) begin
        bad++;
        $display("FAIL b2b_wrap got=%h,%h want=ff,00", got_q[base + 510][8:1], got_q[base + 512][8:1]);
      end
      total++;
      if (got_cyc[base + 2] - got_cyc[base] !== 3) begin
        bad++;
        $display("FAIL b2b_min_packet got=%0d want=3", got_cyc[base + 2] - got_cyc[base]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < got_q.size()) begin
        total++;
        if (got_q[rd_idx] !== e) begin
          bad++;
          $display("FAIL b2b_flit idx=%0d got=%h want=%h", rd_idx, got_q[rd_idx], e);
        end
        rd_idx++;
      end
    end
    rd_idx = got_q.size();
  endtask

  task automatic test_mid_reset();
    int base;
    logic [31:0] e;
    base = rd_idx;
    send_packet(4'h7, 12'd5, 28'h300, 0, 2);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pkt_id = 8'h00;
    bus.pl_valid = 1'b1;
    bus.pl_data  = 28'h3FF;
    repeat (10) @(posedge clk); #1;
    bus.pl_valid = 1'b0;
    total++;
    if (got_q.size() - base !== 3) begin
      bad++;
      $display("FAIL midrst_no_tail got=%0d want=3", got_q.size() - base);
    end
    send_packet(4'h2, 12'd1, 28'h7, 0, -1);
    repeat (3) @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < got_q.size()) begin
        total++;
        if (got_q[rd_idx] !== e) begin
          bad++;
          $display("FAIL midrst_flit idx=%0d got=%h want=%h", rd_idx, got_q[rd_idx], e);
        end
        rd_idx++;
      end
    end
    total++;
    if (got_q.size() - base !== 5) begin
      bad++;
      $display("FAIL midrst_count got=%0d want=5", got_q.size() - base);
    end
    rd_idx = got_q.size();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len_error();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
